// File: rtl/cqe_dma_writer_if.sv
// Bundles the completion, offset-manager and DMA command signals of cqe_dma_writer.
// Latency: none (wiring only).
// Backpressure: carried by the valid/ready pairs inside (cpl, dma_wr); the manager port is request/response.
// Ports: completion input (i_cpl_valid/o_cpl_ready + payload), offset-manager request/response,
//        DMA write command (o_dma_wr_valid/i_dma_wr_ready + addr/len/data).
interface cqe_dma_writer_if;
  // completion input
  logic         i_cpl_valid;
  logic         o_cpl_ready;
  logic [23:0]  iv_cq_index;
  logic [31:0]  iv_cq_size;
  logic [63:0]  iv_cq_base;
  logic [255:0] iv_cqe_data;
  // offset manager (RTC port)
  logic         o_cqm_req_valid;
  logic [23:0]  ov_cqm_cq_index;
  logic [31:0]  ov_cqm_cq_size;
  logic         i_cqm_resp_valid;
  logic [23:0]  iv_cqm_cq_offset;
  // DMA write command
  logic         o_dma_wr_valid;
  logic         i_dma_wr_ready;
  logic [63:0]  ov_dma_wr_addr;
  logic [11:0]  ov_dma_wr_len;
  logic [255:0] ov_dma_wr_data;

  // Environment side: produces completions, manager responses and DMA ready.
  modport master (
    output i_cpl_valid, iv_cq_index, iv_cq_size, iv_cq_base, iv_cqe_data,
    output i_cqm_resp_valid, iv_cqm_cq_offset, i_dma_wr_ready,
    input  o_cpl_ready, o_cqm_req_valid, ov_cqm_cq_index, ov_cqm_cq_size,
    input  o_dma_wr_valid, ov_dma_wr_addr, ov_dma_wr_len, ov_dma_wr_data
  );

  // Writer side.
  modport slave (
    input  i_cpl_valid, iv_cq_index, iv_cq_size, iv_cq_base, iv_cqe_data,
    input  i_cqm_resp_valid, iv_cqm_cq_offset, i_dma_wr_ready,
    output o_cpl_ready, o_cqm_req_valid, ov_cqm_cq_index, ov_cqm_cq_size,
    output o_dma_wr_valid, ov_dma_wr_addr, ov_dma_wr_len, ov_dma_wr_data
  );
endinterface

// File: rtl/cqe_dma_writer.sv
// Takes one completion, fetches its CQ write offset from the offset manager, issues one CQE_LEN-byte DMA write.
// Latency: accept T -> manager request T+1 -> response T+2 (idle manager) -> DMA command T+3; 1 CQE per 4 cycles peak.
// Backpressure: one completion in flight; o_cpl_ready low until the DMA handshake; DMA command held until i_dma_wr_ready.
// Ports: clk, rst_n (async active-low); bus (completion / manager / DMA signals, slave modport);
//        ov_cpl_cnt (completed DMA writes, wraps); o_err_timeout (sticky: manager response overdue).
module cqe_dma_writer #(
  parameter int CQE_LEN     = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cqe_dma_writer_if.slave       bus,
  output logic [31:0]           ov_cpl_cnt,
  output logic                  o_err_timeout
);

  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OFFSET_REQ = 2'd1,
    DMA_OUT    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [23:0]    index_q;
  logic [31:0]    size_q;
  logic [63:0]    base_q;
  logic [255:0]   data_q;
  logic [63:0]    addr_q;
  logic [TW-1:0]  tmo_cnt_q;
  logic [31:0]    cpl_cnt_q;
  logic           err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and outputs; all outputs are decoded from the state so that
  // the inactive interfaces read as zero.
  always_comb begin
    state_d             = state_q;
    bus.o_cpl_ready     = 1'b0;
    bus.o_cqm_req_valid = 1'b0;
    bus.ov_cqm_cq_index = '0;
    bus.ov_cqm_cq_size  = '0;
    bus.o_dma_wr_valid  = 1'b0;
    bus.ov_dma_wr_addr  = '0;
    bus.ov_dma_wr_len   = '0;
    bus.ov_dma_wr_data  = '0;
    case (state_q)
      IDLE: begin
        // Gated with rst_n so ready reads low while reset is held.
        bus.o_cpl_ready = rst_n;
        if (bus.i_cpl_valid) state_d = OFFSET_REQ;
      end
      OFFSET_REQ: begin
        // Drop the request in the response cycle itself so the manager
        // never sees it for a second cycle and advances the offset twice.
        bus.o_cqm_req_valid = !bus.i_cqm_resp_valid;
        bus.ov_cqm_cq_index = index_q;
        bus.ov_cqm_cq_size  = size_q;
        if (bus.i_cqm_resp_valid) state_d = DMA_OUT;
      end
      DMA_OUT: begin
        bus.o_dma_wr_valid = 1'b1;
        bus.ov_dma_wr_addr = addr_q;
        bus.ov_dma_wr_len  = 12'(CQE_LEN);
        bus.ov_dma_wr_data = data_q;
        if (bus.i_dma_wr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: completion capture, address formation, timeout and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q   <= '0;
      size_q    <= '0;
      base_q    <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      tmo_cnt_q <= '0;
      cpl_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_cpl_valid) begin
            index_q   <= bus.iv_cq_index;
            size_q    <= bus.iv_cq_size;
            base_q    <= bus.iv_cq_base;
            data_q    <= bus.iv_cqe_data;
            tmo_cnt_q <= '0;
          end
        end
        OFFSET_REQ: begin
          if (bus.i_cqm_resp_valid) begin
            addr_q <= base_q + {40'b0, bus.iv_cqm_cq_offset};
          end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
            // Flag rises together with the counter reaching its limit.
            if (tmo_cnt_q == TMO_MAX - TW'(1)) err_q <= 1'b1;
          end
        end
        DMA_OUT: begin
          if (bus.i_dma_wr_ready) cpl_cnt_q <= cpl_cnt_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign ov_cpl_cnt    = cpl_cnt_q;
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_cqe_dma_writer.sv
// Bench for cqe_dma_writer: table of directed completions plus hand-written
// timeout, stray-response and mid-DMA reset sequences.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_cqe_dma_writer;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpl_cnt;
  logic        err_timeout;

  cqe_dma_writer_if bus ();

  cqe_dma_writer #(.CQE_LEN(32), .TIMEOUT_CYC(255)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .ov_cpl_cnt    (cpl_cnt),
    .o_err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int cur = 0;

  typedef struct {
    logic [63:0]  base;
    logic [23:0]  idx;
    logic [31:0]  size;
    logic [255:0] data;
    logic [23:0]  off;
    int           dly;   // cycles the request is held before the response
    int           bp;    // cycles DMA ready is held low
    logic [63:0]  exp_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %0h expected %0h", cur, nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_cpl_valid      = 1'b0;
    bus.iv_cq_index      = '0;
    bus.iv_cq_size       = '0;
    bus.iv_cq_base       = '0;
    bus.iv_cqe_data      = '0;
    bus.i_cqm_resp_valid = 1'b0;
    bus.iv_cqm_cq_offset = '0;
    bus.i_dma_wr_ready   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    bus.i_cpl_valid = 1'b1;
    bus.iv_cq_index = v.idx;
    bus.iv_cq_size  = v.size;
    bus.iv_cq_base  = v.base;
    bus.iv_cqe_data = v.data;
    @(negedge clk);
    chk("accept_ready", bus.o_cpl_ready, 1);
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 0; k < v.dly; k++) begin
      @(negedge clk);
      chk("req_valid", bus.o_cqm_req_valid, 1);
      chk("req_index", bus.ov_cqm_cq_index, v.idx);
      chk("req_size", bus.ov_cqm_cq_size, v.size);
      chk("busy_ready", bus.o_cpl_ready, 0);
      @(posedge clk); #1;
    end
    bus.i_cqm_resp_valid = 1'b1;
    bus.iv_cqm_cq_offset = v.off;
    @(negedge clk);
    chk("req_drop_on_resp", bus.o_cqm_req_valid, 0);
    chk("resp_cycle_dma", bus.o_dma_wr_valid, 0);
    @(posedge clk); #1;
    bus.i_cqm_resp_valid = 1'b0;
    bus.iv_cqm_cq_offset = '0;
    for (int b = 0; b < v.bp; b++) begin
      @(negedge clk);
      chk("bp_valid", bus.o_dma_wr_valid, 1);
      chk("bp_addr", bus.ov_dma_wr_addr, v.exp_addr);
      chk("bp_len", bus.ov_dma_wr_len, 32);
      chk("bp_data", bus.ov_dma_wr_data, v.data);
      chk("bp_ready", bus.o_cpl_ready, 0);
      chk("bp_no_req", bus.o_cqm_req_valid, 0);
      @(posedge clk); #1;
    end
    bus.i_dma_wr_ready = 1'b1;
    @(negedge clk);
    chk("dma_valid", bus.o_dma_wr_valid, 1);
    chk("dma_addr", bus.ov_dma_wr_addr, v.exp_addr);
    chk("dma_len", bus.ov_dma_wr_len, 32);
    chk("dma_data", bus.ov_dma_wr_data, v.data);
    chk("dma_no_req", bus.o_cqm_req_valid, 0);
    chk("dma_cnt_before", cpl_cnt, 32'(exp_cnt));
    @(posedge clk); #1;
    bus.i_dma_wr_ready = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("done_cnt", cpl_cnt, 32'(exp_cnt));
    chk("done_ready", bus.o_cpl_ready, 1);
    chk("done_dma_valid", bus.o_dma_wr_valid, 0);
    chk("done_dma_addr", bus.ov_dma_wr_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h0000_0001_0000_0000, 24'd5, 32'd6, {32{8'hA5}}, 24'h000040, 1, 0,
                64'h0000_0001_0000_0040};
    vecs[1] = '{64'h0000_0000_1000_0000, 24'hABCDEF, 32'd10, {8{32'hDEADBEEF}}, 24'h000080, 1, 10,
                64'h0000_0000_1000_0080};
    vecs[2] = '{64'h0000_0000_0000_2000, 24'hFFFFFF, 32'hFFFF_FFFF, {16{16'h1234}}, 24'h123460, 3, 0,
                64'h0000_0000_0012_5460};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFE0, 24'd1, 32'd4, {64{4'h3}}, 24'h000020, 1, 0,
                64'h0000_0000_0000_0000};
    vecs[4] = '{64'h0000_0000_FFFF_FFF0, 24'd2, 32'd5, {32{8'h5A}}, 24'h000020, 1, 0,
                64'h0000_0001_0000_0010};
    vecs[5] = '{64'h0000_00FF_0000_0000, 24'h000777, 32'd12, {4{64'h0123_4567_89AB_CDEF}}, 24'hFFFFFF, 2, 2,
                64'h0000_00FF_00FF_FFFF};

    idle_inputs();
    rst_n = 1'b0;
    #23;
    chk("rst_ready_low", bus.o_cpl_ready, 0);
    chk("rst_cnt", cpl_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.o_cpl_ready, 1);
    chk("rst_req", bus.o_cqm_req_valid, 0);
    chk("rst_dma", bus.o_dma_wr_valid, 0);
    chk("rst_err", err_timeout, 0);

    for (int i = 0; i < 6; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // A response in IDLE must not start anything.
    cur = 100;
    @(posedge clk); #1;
    bus.i_cqm_resp_valid = 1'b1;
    bus.iv_cqm_cq_offset = 24'h55;
    @(negedge clk);
    chk("stray_ready", bus.o_cpl_ready, 1);
    @(posedge clk); #1;
    bus.i_cqm_resp_valid = 1'b0;
    @(negedge clk);
    chk("stray_dma", bus.o_dma_wr_valid, 0);
    chk("stray_ready2", bus.o_cpl_ready, 1);
    chk("stray_cnt", cpl_cnt, 32'(exp_cnt));

    // Timeout: 256 waiting cycles, flag rises after the 255th, late response still completes.
    cur = 101;
    @(posedge clk); #1;
    bus.i_cpl_valid = 1'b1;
    bus.iv_cq_index = 24'd9;
    bus.iv_cq_size  = 32'd3;
    bus.iv_cq_base  = 64'h0000_0000_0040_0000;
    bus.iv_cqe_data = {8{32'hC0DE_0001}};
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 1)   chk("tmo_req_first", bus.o_cqm_req_valid, 1);
      if (k == 255) chk("tmo_err_before", err_timeout, 0);
      if (k == 256) begin
        chk("tmo_err_set", err_timeout, 1);
        chk("tmo_req_held", bus.o_cqm_req_valid, 1);
        chk("tmo_idx_held", bus.ov_cqm_cq_index, 24'd9);
      end
      @(posedge clk); #1;
    end
    bus.i_cqm_resp_valid = 1'b1;
    bus.iv_cqm_cq_offset = 24'h000100;
    @(negedge clk);
    chk("tmo_req_drop", bus.o_cqm_req_valid, 0);
    @(posedge clk); #1;
    bus.i_cqm_resp_valid = 1'b0;
    bus.i_dma_wr_ready   = 1'b1;
    @(negedge clk);
    chk("tmo_dma_valid", bus.o_dma_wr_valid, 1);
    chk("tmo_dma_addr", bus.ov_dma_wr_addr, 64'h0000_0000_0040_0100);
    @(posedge clk); #1;
    bus.i_dma_wr_ready = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("tmo_cnt", cpl_cnt, 32'(exp_cnt));
    chk("tmo_err_sticky", err_timeout, 1);

    // Reset while the DMA command is pending.
    cur = 102;
    @(posedge clk); #1;
    bus.i_cpl_valid = 1'b1;
    bus.iv_cq_base  = 64'h1000;
    bus.iv_cqe_data = {32{8'h77}};
    @(posedge clk); #1;
    idle_inputs();
    bus.i_cqm_resp_valid = 1'b1;
    bus.iv_cqm_cq_offset = 24'h20;
    @(posedge clk); #1;
    bus.i_cqm_resp_valid = 1'b0;
    @(negedge clk);
    chk("mid_dma_valid", bus.o_dma_wr_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dma_valid", bus.o_dma_wr_valid, 0);
    chk("arst_dma_addr", bus.ov_dma_wr_addr, 0);
    chk("arst_dma_data", bus.ov_dma_wr_data, 0);
    chk("arst_ready", bus.o_cpl_ready, 0);
    chk("arst_cnt", cpl_cnt, 0);
    chk("arst_err", err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    #1;
    chk("post_rst_ready", bus.o_cpl_ready, 1);
    chk("post_rst_cnt", cpl_cnt, 0);
    cur = 0;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cqe_dma_writer.md
# cqe_dma_writer

Downstream consumer of the completion-queue offset manager on the RTC path. It accepts one completion (CQ index, CQ size, CQ base address, 32-byte CQE payload) and requests the current write offset for that CQ from the offset manager. It then forms the host address `base + offset` and issues a single 32-byte DMA write carrying the CQE. It serialises completions, holding the manager request exactly until the response arrives so the manager's offset advances once per CQE.

## Interface
Parameters
- CQE_LEN, 32, CQE size in bytes; also the DMA write length
- TIMEOUT_CYC, 255, cycles in OFFSET_REQ before the timeout flag is set

Ports
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_cpl_valid  in  1  completion request valid
- o_cpl_ready  out  1  block can accept a completion
- iv_cq_index  in  24  CQ number
- iv_cq_size  in  32  log2 of CQ entry count
- iv_cq_base  in  64  CQ buffer base address
- iv_cqe_data  in  256  CQE payload
- o_cqm_req_valid  out  1  offset request to the manager (RTC port)
- ov_cqm_cq_index  out  24  CQ index to the manager
- ov_cqm_cq_size  out  32  CQ size to the manager
- i_cqm_resp_valid  in  1  manager response valid
- iv_cqm_cq_offset  in  24  byte offset returned by the manager
- o_dma_wr_valid  out  1  DMA write command valid
- i_dma_wr_ready  in  1  DMA engine accepts the command
- ov_dma_wr_addr  out  64  host write address
- ov_dma_wr_len  out  12  write length in bytes
- ov_dma_wr_data  out  256  CQE payload
- ov_cpl_cnt  out  32  count of completed DMA writes
- o_err_timeout  out  1  sticky flag: manager response overdue

## Operation
- FSM states: IDLE, OFFSET_REQ, DMA_OUT. Reset state is IDLE.
- IDLE
  - o_cpl_ready=1.
  - On i_cpl_valid&o_cpl_ready, register index, size, base and data, clear the timeout counter, and go to OFFSET_REQ.
- OFFSET_REQ
  - o_cqm_req_valid = !i_cqm_resp_valid. This is combinational, so the request deasserts in the same cycle the response is seen and never overlaps a second manager cycle.
  - ov_cqm_cq_index and ov_cqm_cq_size are driven from the registered values.
  - On i_cqm_resp_valid: register addr = base + {40'b0, iv_cqm_cq_offset}, computed mod 2^64 with carry propagated. Then go to DMA_OUT.
  - Each cycle without a response, the timeout counter increments and saturates at TIMEOUT_CYC.
  - When the counter reaches TIMEOUT_CYC, o_err_timeout is set and stays set until reset. The request keeps being held; there is no abort.
- DMA_OUT
  - o_dma_wr_valid=1, with addr, len=CQE_LEN and data stable until handshake.
  - On i_dma_wr_ready: ov_cpl_cnt increments (wraps 2^32-1 -> 0) and the FSM goes to IDLE.
- Outside OFFSET_REQ, o_cqm_req_valid=0 and ov_cqm_* = 0.
- Outside DMA_OUT, o_dma_wr_valid=0 and ov_dma_wr_* = 0.
- A response arriving in IDLE or DMA_OUT is ignored.
- The CQ index and CQ size are passed to the manager unmodified. Wrap-around of the offset is the manager's responsibility.

## Timing
- Reset values: o_cpl_ready=1 once rst_n is high, else 0; every other output 0, ov_cpl_cnt=0, o_err_timeout=0.
- Reset mid-operation: the pending completion is dropped and the FSM returns to IDLE immediately (asynchronous).
- Accept at cycle T (valid&ready) gives:
  - T+1: o_cqm_req_valid=1.
  - T+2: response from an idle manager; o_cqm_req_valid=0 in that cycle.
  - T+3: o_dma_wr_valid=1.
- With i_dma_wr_ready high at T+3, the FSM is back in IDLE at T+4 and o_cpl_ready=1 at T+4. Peak throughput is 1 CQE per 4 cycles.
- Each response cycle of delay adds one cycle of latency.
- o_cpl_ready is low from T+1 until the cycle after the DMA handshake.

## Test plan
- Basic: base=0x0000_0001_0000_0000, idx=5, size=6, data=0xA5..A5, manager replies offset 0x40 at T+2. Required: o_dma_wr_valid at T+3, addr=0x0000_0001_0000_0040, len=32, data=0xA5..A5, ov_cpl_cnt=1.
- Backpressure: i_dma_wr_ready low for 10 cycles. Required: addr, len and data are stable throughout, o_cpl_ready=0, exactly one write accepted, counter +1.
- Delayed response: manager replies 3 cycles late. Required: o_cqm_req_valid high for exactly 3 cycles then 0 in the response cycle, no second request, index and size stable.
- Timeout: no response for 256 cycles. Required: o_err_timeout=1 after the 255th waiting cycle and remains 1; request still held; a late response then completes the write normally.
- Address carry: base=0xFFFF_FFFF_FFFF_FFE0, offset 0x20. Required: addr=0x0. Separately, base=0x0000_0000_FFFF_FFF0, offset 0x20, required: addr=0x0000_0001_0000_0010.
- Reset mid-DMA_OUT: assert rst_n=0 while o_dma_wr_valid=1. Required: all outputs go to 0 immediately; after release o_cpl_ready=1, ov_cpl_cnt=0, and the next completion works.
